// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Each grant is a burst of up to BURST_MAX words; winc is never issued while wfull is high.
module afifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int BURST_MAX  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [15:0]                   stall_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0]          BURST_LAST = 8'(BURST_MAX - 1);
    localparam logic [ID_WIDTH-1:0] LAST_REQ   = ID_WIDTH'(NUM_REQ - 1);

    state_t              state;
    logic [ID_WIDTH-1:0] last_grant;
    logic [7:0]          burst_cnt;
    logic [ID_WIDTH-1:0] pick_id;
    logic                pick_found;
    logic                cur_valid;

    // Rotating priority search: first valid requester after last_grant, with wrap.
    always_comb begin : pick_blk
        int                  idx;
        logic [ID_WIDTH-1:0] cand;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(last_grant) + 1 + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_WIDTH'(idx);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Write-port steering is combinational so a word moves in the cycle it is offered.
    always_comb begin
        req_ready = '0;
        wdata     = '0;
        cur_valid = req_valid[grant_id];
        if (state == GRANT) begin
            req_ready[grant_id] = !wfull;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ID_WIDTH'(i) == grant_id) wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign winc        = (state == GRANT) && cur_valid && !wfull;
    assign grant_valid = (state == GRANT);

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state      <= IDLE;
            last_grant <= LAST_REQ;
            burst_cnt  <= '0;
            grant_id   <= '0;
            stall_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_id;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!cur_valid) begin
                        // A requester that drops valid forfeits the rest of its burst.
                        state      <= IDLE;
                        last_grant <= grant_id;
                    end else if (wfull) begin
                        if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
                    end else begin
                        burst_cnt <= burst_cnt + 8'd1;
                        if (burst_cnt == BURST_LAST) begin
                            state      <= IDLE;
                            last_grant <= grant_id;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Scoreboard bench for afifo_wr_arbiter: directed bursts, wfull stalls, forfeits,
// mid-burst reset and stall counter saturation.
module tb_afifo_wr_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int BM = 4;
    localparam int IW = 2;

    logic             wclk;
    logic             wrst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic             wfull;
    logic             winc;
    logic [DW-1:0]    wdata;
    logic             grant_valid;
    logic [IW-1:0]    grant_id;
    logic [15:0]      stall_cnt;

    afifo_wr_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ   (NR),
        .BURST_MAX (BM),
        .ID_WIDTH  (IW)
    ) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wfull      (wfull),
        .winc       (winc),
        .wdata      (wdata),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .stall_cnt  (stall_cnt)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    int            wr_cyc[$];
    int            cyc      = 0;
    int            wr_count = 0;
    int            total    = 0;
    int            bad      = 0;
    logic [DW-1:0] rq_mem [NR][32];
    int            rq_head[NR];
    int            rq_tail[NR];

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int id, input int n);
        return DW'(32'hA000_0000 + (id << 16) + n);
    endfunction

    task automatic push(input int id, input int n);
        rq_mem[id][rq_tail[id]] = word(id, n);
        rq_tail[id]++;
    endtask

    task automatic expect_w(input int id, input int n);
        exp_t e;
        e.id   = IW'(id);
        e.data = word(id, n);
        exp_q.push_back(e);
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NR; i++) s += rq_tail[i] - rq_head[i];
        return s;
    endfunction

    task automatic sync();
        @(posedge wclk);
        #2;
    endtask

    task automatic do_reset();
        sync();
        wrst  = 1'b1;
        wfull = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end
        exp_q.delete();
        repeat (2) sync();
        wrst = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || pending() != 0) && n < budget) begin
            @(negedge wclk);
            #1;
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
        repeat (3) @(negedge wclk);
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        int n = 0;
        while (wr_count < target && n < budget) begin
            @(negedge wclk);
            #1;
            n++;
        end
        check({tag, "_reached"}, wr_count, target);
    endtask

    // Requester model: offers its queued words in order, holding each until accepted.
    initial begin : driver
        logic [NR-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge wclk);
            acc = req_valid & req_ready;
            @(posedge wclk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (wrst) begin
                    req_valid[i] = 1'b0;
                end else begin
                    if (acc[i]) rq_head[i]++;
                    if (rq_head[i] < rq_tail[i]) begin
                        req_valid[i]           = 1'b1;
                        req_data[i*DW +: DW]   = rq_mem[i][rq_head[i]];
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: every FIFO write is popped against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge wclk);
            cyc++;
            if (!wrst) begin
                if (req_ready != '0) check("ready_onehot", 32'($countones(req_ready)), 1);
                if (winc) begin
                    wr_count++;
                    wr_cyc.push_back(cyc);
                    check("winc_while_full", 32'(wfull), 0);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got id=%0d data=%0h expected none", grant_id, wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("wdata", wdata, e.data);
                        check("wr_grant_id", 32'(grant_id), 32'(e.id));
                    end
                end
            end
        end
    end

    initial begin : main
        wrst  = 1'b1;
        wfull = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        check("reset_winc", 32'(winc), 0);
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_grant_valid", 32'(grant_valid), 0);
        check("reset_grant_id", 32'(grant_id), 0);
        check("reset_stall_cnt", 32'(stall_cnt), 0);
        check("reset_wdata", wdata, 0);
        sync();
        wrst = 1'b0;

        // Single requester, six words: burst of 4, arbitration gap, then 2.
        sync();
        wr_cyc.delete();
        for (int n = 0; n < 6; n++) begin
            push(1, n);
            expect_w(1, n);
        end
        wait_drain("t1", 100);
        check("t1_writes", wr_cyc.size(), 6);
        if (wr_cyc.size() == 6) begin
            check("t1_burst_span", 32'(wr_cyc[3] - wr_cyc[0]), 3);
            check("t1_regrant_gap", 32'(wr_cyc[4] - wr_cyc[3]), 2);
            check("t1_tail", 32'(wr_cyc[5] - wr_cyc[4]), 1);
        end

        // Requesters 0 and 2 alternate in bursts of 4.
        do_reset();
        wr_cyc.delete();
        for (int b = 0; b < 2; b++) begin
            for (int n = 0; n < 4; n++) expect_w(0, b*4 + n);
            for (int n = 0; n < 4; n++) expect_w(2, b*4 + n);
        end
        for (int n = 0; n < 8; n++) begin
            push(0, n);
            push(2, n);
        end
        wait_drain("t2", 200);
        check("t2_writes", wr_cyc.size(), 16);
        if (wr_cyc.size() == 16) begin
            for (int g = 1; g < 4; g++) check("t2_gap", 32'(wr_cyc[4*g] - wr_cyc[4*g-1]), 2);
        end

        // Requester 3 stalled by wfull for five cycles mid-burst.
        do_reset();
        wr_cyc.delete();
        for (int n = 0; n < 4; n++) begin
            push(3, n);
            expect_w(3, n);
        end
        wait_writes("t3_pre", wr_count + 2, 50);
        @(posedge wclk);
        #2;
        wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge wclk);
            check("t3_winc", 32'(winc), 0);
            check("t3_ready", 32'(req_ready), 0);
            check("t3_grant_id", 32'(grant_id), 3);
            @(posedge wclk);
        end
        #2;
        wfull = 1'b0;
        wait_drain("t3", 100);
        check("t3_stall_cnt", 32'(stall_cnt), 5);
        check("t3_writes", wr_cyc.size(), 4);
        if (wr_cyc.size() == 4) begin
            check("t3_stall_gap", 32'(wr_cyc[2] - wr_cyc[1]), 6);
            check("t3_resume", 32'(wr_cyc[3] - wr_cyc[2]), 1);
        end

        // Reset asserted during the third word of requester 2's burst.
        sync();
        push(0, 0);
        expect_w(0, 0);
        for (int n = 0; n < 4; n++) push(2, n);
        for (int n = 0; n < 3; n++) expect_w(2, n);
        wait_writes("t5_pre", wr_count + 4, 60);
        wrst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end
        #1;
        check("t5_winc", 32'(winc), 0);
        check("t5_ready", 32'(req_ready), 0);
        check("t5_grant_valid", 32'(grant_valid), 0);
        check("t5_stall_cnt", 32'(stall_cnt), 0);
        check("t5_grant_id", 32'(grant_id), 0);
        check("t5_wdata", wdata, 0);
        check("t5_pending", exp_q.size(), 0);
        repeat (2) sync();
        wrst = 1'b0;
        sync();
        push(3, 0);
        push(0, 0);
        expect_w(0, 0);
        expect_w(3, 0);
        wait_drain("t5", 60);

        // Requester 0 forfeits after two words; requester 1 follows.
        do_reset();
        wr_cyc.delete();
        push(0, 0);
        push(0, 1);
        push(1, 0);
        push(1, 1);
        expect_w(0, 0);
        expect_w(0, 1);
        expect_w(1, 0);
        expect_w(1, 1);
        wait_drain("t4", 60);
        check("t4_writes", wr_cyc.size(), 4);
        if (wr_cyc.size() == 4) check("t4_release_gap", 32'(wr_cyc[2] - wr_cyc[1]), 3);

        // Everyone valid behind a long full condition: counter saturates, grant stays on 0.
        do_reset();
        wfull = 1'b1;
        for (int i = 0; i < NR; i++) begin
            push(i, 0);
            expect_w(i, 0);
        end
        begin
            int base;
            base = wr_count;
            repeat (70000) @(posedge wclk);
            @(negedge wclk);
            check("t6_stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
            check("t6_grant_id", 32'(grant_id), 0);
            check("t6_grant_valid", 32'(grant_valid), 1);
            check("t6_no_writes", wr_count, base);
        end
        sync();
        wfull = 1'b0;
        wait_drain("t6", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
